axis_downsizer: RTL

AXIS_DOWNSIZER -- requirements
Module: axis_downsizer

---
 rtl/axis_downsizer_if.sv | 15 +
 rtl/axis_downsizer.sv | 91 +++++++++
 2 files changed

// File: rtl/axis_downsizer_if.sv
// Stream bundle (valid/ready/data/keep/last) shared by the downsizer input and output sides.
// Master drives payload and valid; slave drives ready.
interface axis_downsizer_if #(
  parameter int DATA_W = 8,
  parameter int KEEP_W = 1
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [KEEP_W-1:0] keep;
  logic              last;

  modport master (output valid, output data, output keep, output last, input ready);
  modport slave  (input valid, input data, input keep, input last, output ready);
endinterface

// File: rtl/axis_downsizer.sv
// Splits each BUS_W input beat into OUT_W sub-beats, trimming chunks above the highest kept word.
// First sub-beat one cycle after capture; input ready only when the last chunk leaves (or idle).
module axis_downsizer #(
  parameter int WORD_W = 8,
  parameter int BUS_W  = 32,
  parameter int OUT_W  = 8
) (
  input  logic             clk,
  input  logic             rstn,
  axis_downsizer_if.slave  s_axis,
  axis_downsizer_if.master m_axis
);
  localparam int R  = BUS_W / OUT_W;
  localparam int KW = BUS_W / WORD_W;
  localparam int CW = OUT_W / WORD_W;
  localparam int IW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic {EMPTY = 1'b0, SEND = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [BUS_W-1:0] data_q, data_d;
  logic [KW-1:0]   keep_q, keep_d;
  logic            last_q, last_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   n_q, n_d;
  logic [IW-1:0]   cap_n;
  logic            idx_last;
  logic            capture;
  logic            keep_zero;

  always_comb begin
    cap_n = '0;
    for (int c = 0; c < R; c++) begin
      if (|s_axis.keep[c*CW +: CW]) cap_n = IW'(c);
    end
  end

  assign idx_last     = (idx_q == n_q);
  assign s_axis.ready = (state_q == EMPTY) || (m_axis.ready && idx_last);
  assign capture      = s_axis.valid && s_axis.ready;
  assign keep_zero    = ~|s_axis.keep;

  // Held beat is shifted down per sub-beat so outputs come straight from register LSBs.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    idx_d   = idx_q;
    n_d     = n_q;
    if (capture) begin
      state_d = (keep_zero && !s_axis.last) ? EMPTY : SEND;
      data_d  = keep_zero ? '0 : s_axis.data;
      keep_d  = s_axis.keep;
      last_d  = s_axis.last;
      idx_d   = '0;
      n_d     = cap_n;
    end else if (state_q == SEND && m_axis.ready) begin
      if (!idx_last) begin
        idx_d  = idx_q + IW'(1);
        data_d = data_q >> OUT_W;
        keep_d = keep_q >> CW;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= EMPTY;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
    end
  end

  assign m_axis.valid = (state_q == SEND);
  assign m_axis.data  = data_q[OUT_W-1:0];
  assign m_axis.keep  = keep_q[CW-1:0];
  assign m_axis.last  = (state_q == SEND) && last_q && idx_last;
endmodule
